// File: rtl/fp_div_pkg.sv
// Shared constants and helpers for the FP32 divider result path.
// Exports DIV_LAT, FP_W and cnt_w() (credit counter width).
package fp_div_pkg;

    localparam int DIV_LAT = 8;
    localparam int FP_W    = 32;

    // Width needed to hold 0..depth inclusive.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Synchronous FIFO with registered pointers and combinational read.
// Ports: clk, rst, push, pop, din -> dout (raw head), full, empty, occ.
module fp_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] occ
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty = (occ_q == '0);
    assign full  = (occ_q == FULL_OCC);
    assign occ   = occ_q;
    assign dout  = mem_q[rd_ptr_q];

    // When full, a simultaneous pop frees the slot the push lands in
    // (wr_ptr == rd_ptr); the head is read before the edge overwrites it.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   occ_d = occ_q + (AW + 1)'(1);
            2'b01:   occ_d = occ_q - (AW + 1)'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= din;
    end

endmodule

// File: rtl/fp_div_result_buf.sv
// Result buffer and issue-credit tracker behind the fixed-latency divider.
// Ports: en/issue/res_vld/res_data in; out_vld/out_data/out_rdy handshake;
// can_issue, count (outstanding ops) and sticky err out.
module fp_div_result_buf
    import fp_div_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = FP_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     issue,
    input  logic                     res_vld,
    input  logic [WIDTH-1:0]         res_data,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [WIDTH-1:0]         out_data,
    output logic                     can_issue,
    output logic [cnt_w(DEPTH)-1:0]  count,
    output logic                     err
);

    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] CMAX = CW'(DEPTH);

    logic             push, pop, iss;
    logic             full, empty;
    logic [WIDTH-1:0] head;
    logic [CW-1:0]    occ;
    logic [CW-1:0]    count_q, count_d;
    logic             err_q, err_d;

    // Output side ignores en so the consumer can drain a frozen divider.
    assign push = res_vld & en;
    assign iss  = issue & en;
    assign pop  = out_vld & out_rdy;

    fp_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (res_data),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .occ   (occ)
    );

    assign out_vld   = (occ != '0);
    assign out_data  = empty ? '0 : head;
    assign can_issue = (count_q < CMAX);
    assign count     = count_q;
    assign err       = err_q;

    always_comb begin
        count_d = count_q;
        err_d   = err_q;
        // Issuing without credit or overflowing the buffer is a protocol error.
        if (iss && count_q == CMAX)  err_d = 1'b1;
        if (push && full && !pop)    err_d = 1'b1;
        case ({iss, pop})
            2'b10: if (count_q != CMAX) count_d = count_q + CW'(1);
            2'b01: if (count_q != '0)   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_fp_div_result_buf.sv
// Self-checking bench for fp_div_result_buf: vector table, directed
// corner sequences and a randomized run against a queue-based model.
module tb_fp_div_result_buf;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        issue = 1'b0;
    logic        res_vld = 1'b0;
    logic [31:0] res_data = '0;
    logic        out_vld;
    logic        out_rdy = 1'b0;
    logic [31:0] out_data;
    logic        can_issue;
    logic [4:0]  count;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [31:0] mq[$];
    int          mcnt = 0;
    bit          merr = 1'b0;

    fp_div_result_buf #(.DEPTH(16), .WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .issue     (issue),
        .res_vld   (res_vld),
        .res_data  (res_data),
        .out_vld   (out_vld),
        .out_rdy   (out_rdy),
        .out_data  (out_data),
        .can_issue (can_issue),
        .count     (count),
        .err       (err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] x);
        checks++;
        if (a !== x) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, a, x);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        mcnt = 0;
        merr = 1'b0;
    endtask

    task automatic model_step(input bit e, input bit i, input bit v,
                              input logic [31:0] d, input bit r);
        bit p, pu, is, was_full;
        p        = r && (mq.size() != 0);
        pu       = e && v;
        is       = e && i;
        was_full = (mq.size() == 16);
        if (p) void'(mq.pop_front());
        if (pu) begin
            if (was_full && !p) merr = 1'b1;
            else mq.push_back(d);
        end
        if (is && mcnt == 16) merr = 1'b1;
        if (is && !p && mcnt < 16) mcnt++;
        else if (p && !is && mcnt > 0) mcnt--;
    endtask

    task automatic check_model();
        chk("m_out_vld", out_vld, mq.size() != 0);
        chk("m_out_data", out_data, (mq.size() != 0) ? mq[0] : 32'h0);
        chk("m_count", count, mcnt);
        chk("m_can_issue", can_issue, mcnt < 16);
        chk("m_err", err, merr);
    endtask

    // Inputs applied at negedge, state advances at posedge, checked at next negedge.
    task automatic cyc(input bit e, input bit i, input bit v,
                       input logic [31:0] d, input bit r);
        en = e; issue = i; res_vld = v; res_data = d; out_rdy = r;
        @(posedge clk);
        model_step(e, i, v, d, r);
        @(negedge clk);
        check_model();
    endtask

    task automatic do_reset();
        en = 0; issue = 0; res_vld = 0; out_rdy = 0;
        rst = 1'b1;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_model();
    endtask

    typedef struct {
        bit          e, i, v;
        logic [31:0] d;
        bit          r;
        bit          xv;
        logic [31:0] xd;
        int          xc;
        bit          xci;
        bit          xerr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 1, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0};
        for (int k = 1; k < 8; k++)
            tbl[k] = '{1, 0, 0, 32'h0, 0, 0, 32'h0, 1, 1, 0};
        tbl[8] = '{1, 0, 1, 32'h3F800000, 0, 1, 32'h3F800000, 1, 1, 0};
        tbl[9] = '{1, 0, 0, 32'h0, 1, 0, 32'h0, 0, 1, 0};

        // Reset values.
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_out_vld", out_vld, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_count", count, 0);
        chk("rst_can_issue", can_issue, 1);
        chk("rst_err", err, 0);

        // Single op: issue, result 8 cycles later, then pop.
        for (int k = 0; k < 10; k++) begin
            cyc(tbl[k].e, tbl[k].i, tbl[k].v, tbl[k].d, tbl[k].r);
            chk($sformatf("tbl%0d_vld", k), out_vld, tbl[k].xv);
            chk($sformatf("tbl%0d_data", k), out_data, tbl[k].xd);
            chk($sformatf("tbl%0d_count", k), count, tbl[k].xc);
            chk($sformatf("tbl%0d_cani", k), can_issue, tbl[k].xci);
            chk($sformatf("tbl%0d_err", k), err, tbl[k].xerr);
        end

        // 16 back-to-back issues, then 16 results buffered.
        for (int k = 0; k < 16; k++) cyc(1, 1, 0, 32'h0, 0);
        chk("fill_count", count, 16);
        chk("fill_cani", can_issue, 0);
        for (int k = 0; k < 16; k++) cyc(1, 0, 1, 32'hC0000000 + k, 0);
        chk("buf_head", out_data, 32'hC0000000);

        // Full: push and pop in the same cycle.
        cyc(1, 0, 1, 32'h7F7FFFFF, 1);
        chk("pp_err", err, 0);
        chk("pp_vld", out_vld, 1);
        chk("pp_head", out_data, 32'hC0000001);
        chk("pp_count", count, 15);
        chk("pp_cani", can_issue, 1);

        // Drain in order, new word last.
        for (int k = 0; k < 16; k++) begin
            chk($sformatf("drain%0d", k), out_data,
                (k < 15) ? 32'hC0000001 + k : 32'h7F7FFFFF);
            cyc(1, 0, 0, 32'h0, 1);
        end
        chk("drain_vld", out_vld, 0);
        chk("drain_count", count, 0);

        // en low: issue/res_vld ignored, pops still drain.
        for (int k = 0; k < 3; k++) cyc(1, 1, 1, 32'h41000000 + k, 0);
        for (int k = 0; k < 2; k++) cyc(0, k[0], ~k[0], 32'hBAD0BAD0, 0);
        chk("en0_count", count, 3);
        chk("en0_head", out_data, 32'h41000000);
        for (int k = 0; k < 3; k++) cyc(0, ~k[0], k[0], 32'hBAD1BAD1, 1);
        chk("en0_drain_vld", out_vld, 0);
        chk("en0_drain_count", count, 0);

        // Overflow: push while full without pop drops the word, err sticks.
        for (int k = 0; k < 16; k++) cyc(1, 1, 1, 32'h40000000 + k, 0);
        cyc(1, 0, 1, 32'hDEADBEEF, 0);
        chk("ovf_err", err, 1);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);
        chk("ovf_err_sticky", err, 1);
        chk("ovf_head", out_data, 32'h40000000);

        // Async reset with 6 buffered and 3 in flight.
        do_reset();
        for (int k = 0; k < 6; k++) cyc(1, 1, 1, 32'h42000000 + k, 0);
        for (int k = 0; k < 3; k++) cyc(1, 1, 0, 32'h0, 0);
        chk("pre_rst_count", count, 9);
        en = 0; issue = 0; res_vld = 0; out_rdy = 0;
        #2 rst = 1'b1;
        #1;
        chk("arst_vld", out_vld, 0);
        chk("arst_count", count, 0);
        chk("arst_cani", can_issue, 1);
        chk("arst_err", err, 0);
        model_clear();
        @(negedge clk);
        rst = 1'b0;
        check_model();

        // Randomized run against the model.
        for (int n = 0; n < 3000; n++) begin
            bit e, i, v, r;
            if (n % 1000 == 999) do_reset();
            e = ($urandom_range(0, 7) != 0);
            i = (mcnt < 16) && ($urandom_range(0, 1) == 1);
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 3) != 0);
            cyc(e, i, v, $urandom, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
